// File: rtl/cci_mem_responder.sv
// cci_mem_responder: CCI host-memory model with per-channel request queues,
// a programmable minimum response latency and a line-addressed RAM.

module cci_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int SLACK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_alm_full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          r_alm;
    logic [PW:0]   w_cnt_nxt;
    logic          w_push;
    logic          w_pop;

    // Fullness is judged on the current count: a same-cycle pop frees no room.
    assign o_empty    = (r_cnt == '0);
    assign o_full     = (r_cnt == (PW+1)'(DEPTH));
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head     = r_mem[r_rp];
    assign o_alm_full = r_alm;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + (PW+1)'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_alm <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            r_cnt <= w_cnt_nxt;
            r_alm <= (w_cnt_nxt >= (PW+1)'(DEPTH - SLACK));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= i_data;
    end
endmodule

module cci_mem_responder #(
    parameter int ADDR_W         = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int ALM_FULL_SLACK = 4,
    parameter int LATENCY        = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req_valid,
    input  logic [41:0]  rd_req_addr,
    input  logic [15:0]  rd_req_mdata,
    output logic         rd_alm_full,
    output logic         rd_rsp_valid,
    output logic [511:0] rd_rsp_data,
    output logic [15:0]  rd_rsp_mdata,
    input  logic         wr_req_valid,
    input  logic [41:0]  wr_req_addr,
    input  logic [511:0] wr_req_data,
    input  logic [15:0]  wr_req_mdata,
    output logic         wr_alm_full,
    output logic         wr_rsp_valid,
    output logic [15:0]  wr_rsp_mdata,
    input  logic         rsp_stall,
    output logic         overflow,
    output logic [31:0]  rd_total,
    output logic [31:0]  wr_total
);
    localparam int RW = ADDR_W + 32;
    localparam int WW = RW + 512;
    localparam logic [15:0] LAT_M1 = 16'(LATENCY - 1);

    logic [15:0]       r_now;
    logic [511:0]      r_ram [2**ADDR_W] = '{default: '0};
    logic              r_rd_rsp_valid;
    logic [511:0]      r_rd_rsp_data;
    logic [15:0]       r_rd_rsp_mdata;
    logic              r_wr_rsp_valid;
    logic [15:0]       r_wr_rsp_mdata;
    logic              r_overflow;
    logic [31:0]       r_rd_total;
    logic [31:0]       r_wr_total;

    logic [RW-1:0]     w_rd_head;
    logic [WW-1:0]     w_wr_head;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [15:0]       w_rd_mdata;
    logic [15:0]       w_rd_stamp;
    logic [511:0]      w_wr_data;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [15:0]       w_wr_mdata;
    logic [15:0]       w_wr_stamp;
    logic [15:0]       w_rd_age;
    logic [15:0]       w_wr_age;
    logic              w_rd_empty;
    logic              w_wr_empty;
    logic              w_rd_full;
    logic              w_wr_full;
    logic              w_rd_pop;
    logic              w_wr_pop;
    logic              w_unused_addr;

    // Upper address bits are dropped so the RAM aliases modulo 2^ADDR_W.
    assign w_unused_addr = ^{rd_req_addr[41:ADDR_W], wr_req_addr[41:ADDR_W]};

    cci_req_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH),
        .SLACK (ALM_FULL_SLACK)
    ) u_rd_q (
        .clk        (clk),
        .reset      (reset),
        .i_push     (rd_req_valid),
        .i_data     ({rd_req_addr[ADDR_W-1:0], rd_req_mdata, r_now}),
        .i_pop      (w_rd_pop),
        .o_head     (w_rd_head),
        .o_empty    (w_rd_empty),
        .o_full     (w_rd_full),
        .o_alm_full (rd_alm_full)
    );

    cci_req_fifo #(
        .W     (WW),
        .DEPTH (FIFO_DEPTH),
        .SLACK (ALM_FULL_SLACK)
    ) u_wr_q (
        .clk        (clk),
        .reset      (reset),
        .i_push     (wr_req_valid),
        .i_data     ({wr_req_data, wr_req_addr[ADDR_W-1:0],
                      wr_req_mdata, r_now}),
        .i_pop      (w_wr_pop),
        .o_head     (w_wr_head),
        .o_empty    (w_wr_empty),
        .o_full     (w_wr_full),
        .o_alm_full (wr_alm_full)
    );

    assign {w_rd_addr, w_rd_mdata, w_rd_stamp} = w_rd_head;
    assign {w_wr_data, w_wr_addr, w_wr_mdata, w_wr_stamp} = w_wr_head;

    // Age is taken modulo 2^16, so the stamp survives counter wrap.
    assign w_rd_age = r_now - w_rd_stamp;
    assign w_wr_age = r_now - w_wr_stamp;
    assign w_rd_pop = !w_rd_empty && !rsp_stall && (w_rd_age >= LAT_M1);
    assign w_wr_pop = !w_wr_empty && !rsp_stall && (w_wr_age >= LAT_M1);

    always_ff @(posedge clk) begin
        if (w_wr_pop)
            r_ram[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_now          <= '0;
            r_rd_rsp_valid <= 1'b0;
            r_rd_rsp_data  <= '0;
            r_rd_rsp_mdata <= '0;
            r_wr_rsp_valid <= 1'b0;
            r_wr_rsp_mdata <= '0;
            r_overflow     <= 1'b0;
            r_rd_total     <= '0;
            r_wr_total     <= '0;
        end else begin
            r_now          <= r_now + 16'd1;
            r_rd_rsp_valid <= w_rd_pop;
            r_wr_rsp_valid <= w_wr_pop;
            // Read sees the pre-write RAM value on a same-index collision.
            if (w_rd_pop) begin
                r_rd_rsp_data  <= r_ram[w_rd_addr];
                r_rd_rsp_mdata <= w_rd_mdata;
                r_rd_total     <= r_rd_total + 32'd1;
            end
            if (w_wr_pop) begin
                r_wr_rsp_mdata <= w_wr_mdata;
                r_wr_total     <= r_wr_total + 32'd1;
            end
            if ((rd_req_valid && w_rd_full) || (wr_req_valid && w_wr_full))
                r_overflow <= 1'b1;
        end
    end

    assign rd_rsp_valid = r_rd_rsp_valid;
    assign rd_rsp_data  = r_rd_rsp_data;
    assign rd_rsp_mdata = r_rd_rsp_mdata;
    assign wr_rsp_valid = r_wr_rsp_valid;
    assign wr_rsp_mdata = r_wr_rsp_mdata;
    assign overflow     = r_overflow;
    assign rd_total     = r_rd_total;
    assign wr_total     = r_wr_total;
endmodule

// File: tb/tb_cci_mem_responder.sv
// Directed bench for cci_mem_responder: latency, ordering, backpressure,
// overflow, read-before-write, address wrap and mid-run reset.
module tb_cci_mem_responder;
    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req_valid;
    logic [41:0]  rd_req_addr;
    logic [15:0]  rd_req_mdata;
    logic         rd_alm_full;
    logic         rd_rsp_valid;
    logic [511:0] rd_rsp_data;
    logic [15:0]  rd_rsp_mdata;
    logic         wr_req_valid;
    logic [41:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic [15:0]  wr_req_mdata;
    logic         wr_alm_full;
    logic         wr_rsp_valid;
    logic [15:0]  wr_rsp_mdata;
    logic         rsp_stall;
    logic         overflow;
    logic [31:0]  rd_total;
    logic [31:0]  wr_total;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
        int           cyc;
    } rsp_t;

    rsp_t rdq[$];
    rsp_t wrq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [511:0] D_A5 = {64{8'hA5}};
    localparam logic [511:0] D_P  = {16{32'h0909_0001}};
    localparam logic [511:0] D_N  = {16{32'h9999_0002}};
    localparam logic [511:0] D_W  = {16{32'h1029_C0DE}};

    cci_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_mdata (rd_req_mdata),
        .rd_alm_full  (rd_alm_full),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_mdata (rd_rsp_mdata),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_mdata (wr_req_mdata),
        .wr_alm_full  (wr_alm_full),
        .wr_rsp_valid (wr_rsp_valid),
        .wr_rsp_mdata (wr_rsp_mdata),
        .rsp_stall    (rsp_stall),
        .overflow     (overflow),
        .rd_total     (rd_total),
        .wr_total     (wr_total)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_rsp_valid)
            rdq.push_back('{rd_rsp_mdata, rd_rsp_data, cyc});
        if (wr_rsp_valid)
            wrq.push_back('{wr_rsp_mdata, 512'd0, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++)
            tick();
    endtask

    task automatic idle();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [41:0] a, input logic [15:0] m);
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        rd_req_mdata = m;
    endtask

    task automatic wr(input logic [41:0] a, input logic [511:0] d,
                      input logic [15:0] m);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_mdata = m;
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        rsp_stall = 1'b0;
        rd_req_addr = '0;
        rd_req_mdata = '0;
        wr_req_addr = '0;
        wr_req_data = '0;
        wr_req_mdata = '0;
        idle();
        run(2);
        chk("rst_rd_valid", rd_rsp_valid, 0);
        chk("rst_wr_valid", wr_rsp_valid, 0);
        chk("rst_rd_data", rd_rsp_data, 0);
        chk("rst_rd_mdata", rd_rsp_mdata, 0);
        chk("rst_wr_mdata", wr_rsp_mdata, 0);
        chk("rst_alm", {rd_alm_full, wr_alm_full}, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_totals", {rd_total, wr_total}, 0);
        reset = 1'b0;
        tick();

        // write then read of line 5
        c0 = cyc;
        wr(42'd5, D_A5, 16'd3);
        tick();
        idle();
        run(12);
        chk("w1_count", wrq.size(), 1);
        if (wrq.size() > 0) begin
            chk("w1_lat", wrq[0].cyc - c0, 8);
            chk("w1_mdata", wrq[0].mdata, 3);
        end
        chk("w1_total", wr_total, 1);
        chk("w1_onecycle", wr_rsp_valid, 0);
        c0 = cyc;
        rd(42'd5, 16'd7);
        tick();
        idle();
        run(12);
        chk("r1_count", rdq.size(), 1);
        if (rdq.size() > 0) begin
            chk("r1_lat", rdq[0].cyc - c0, 8);
            chk("r1_data", rdq[0].data, D_A5);
            chk("r1_mdata", rdq[0].mdata, 7);
        end
        chk("r1_total", rd_total, 1);

        // 16 back-to-back reads
        rdq.delete();
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            rd(42'(i), 16'(i));
            tick();
        end
        idle();
        run(20);
        chk("b2b_count", rdq.size(), 16);
        for (int i = 0; i < 16 && i < rdq.size(); i++) begin
            chk($sformatf("b2b_mdata%0d", i), rdq[i].mdata, i);
            chk($sformatf("b2b_cyc%0d", i), rdq[i].cyc - c0, 8 + i);
            chk($sformatf("b2b_data%0d", i), rdq[i].data,
                (i == 5) ? D_A5 : 512'd0);
        end

        // stalled queue: almost-full, overflow, drop of 17th
        rdq.delete();
        rsp_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rd(42'd0, 16'(16'h100 + i));
            tick();
            if (i == 10) chk("alm_at11", rd_alm_full, 0);
            if (i == 11) chk("alm_at12", rd_alm_full, 1);
            if (i == 15) chk("ovf_at16", overflow, 0);
        end
        idle();
        chk("ovf_at17", overflow, 1);
        run(10);
        chk("stall_norsp", rdq.size(), 0);
        c0 = cyc;
        rsp_stall = 1'b0;
        run(25);
        chk("stall_count", rdq.size(), 16);
        for (int i = 0; i < 16 && i < rdq.size(); i++) begin
            chk($sformatf("stall_mdata%0d", i), rdq[i].mdata, 16'h100 + i);
            chk($sformatf("stall_cyc%0d", i), rdq[i].cyc - c0, 1 + i);
        end
        chk("stall_alm_clr", rd_alm_full, 0);

        // same-cycle read and write to line 9
        rdq.delete();
        wrq.delete();
        wr(42'd9, D_P, 16'h20);
        tick();
        idle();
        run(12);
        wr(42'd9, D_N, 16'h21);
        rd(42'd9, 16'h22);
        tick();
        idle();
        run(12);
        rd(42'd9, 16'h23);
        tick();
        idle();
        run(12);
        chk("rbw_count", rdq.size(), 2);
        if (rdq.size() > 1) begin
            chk("rbw_old", rdq[0].data, D_P);
            chk("rbw_old_m", rdq[0].mdata, 16'h22);
            chk("rbw_new", rdq[1].data, D_N);
            chk("rbw_same_cyc", rdq[0].cyc, wrq[1].cyc);
        end
        chk("rbw_wcount", wrq.size(), 2);

        // address wrap
        rdq.delete();
        wr(42'd1029, D_W, 16'h30);
        tick();
        idle();
        run(12);
        rd(42'h200_0000_0005, 16'h31);
        tick();
        idle();
        run(12);
        chk("wrap_count", rdq.size(), 1);
        if (rdq.size() > 0)
            chk("wrap_data", rdq[0].data, D_W);
        chk("tot_rd", rd_total, 36);
        chk("tot_wr", wr_total, 4);
        chk("ovf_sticky", overflow, 1);

        // reset with queued reads
        rdq.delete();
        for (int i = 0; i < 4; i++) begin
            rd(42'(i), 16'(16'h50 + i));
            tick();
        end
        idle();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(20);
        chk("rst2_norsp", rdq.size(), 0);
        chk("rst2_totals", {rd_total, wr_total}, 0);
        chk("rst2_alm", rd_alm_full, 0);
        chk("rst2_ovf", overflow, 0);
        c0 = cyc;
        rd(42'd5, 16'h60);
        tick();
        idle();
        run(12);
        chk("rst2_count", rdq.size(), 1);
        if (rdq.size() > 0) begin
            chk("rst2_lat", rdq[0].cyc - c0, 8);
            chk("rst2_ram_kept", rdq[0].data, D_W);
            chk("rst2_mdata", rdq[0].mdata, 16'h60);
        end
        chk("rst2_total", rd_total, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
